// File: rtl/nmea_pkg.sv
// Shared constants, FSM state type and character helpers for the RMC extractor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nmea_pkg;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_ZERO   = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_BODY   = 3'd2,
    ST_CKS_HI = 3'd3,
    ST_CKS_LO = 3'd4
  } state_t;

  // Field number = count of commas seen since the sentence type word.
  localparam logic [3:0] FLD_STATUS = 4'd2;
  localparam logic [3:0] FLD_LAT    = 4'd3;
  localparam logic [3:0] FLD_NS     = 4'd4;
  localparam logic [3:0] FLD_LON    = 4'd5;
  localparam logic [3:0] FLD_EW     = 4'd6;
  localparam logic [3:0] FLD_SPD    = 4'd7;
  localparam logic [3:0] FLD_COG    = 4'd8;

  // Header is talker (2 letters) + "RMC"; index of its last byte.
  localparam logic [2:0] HDR_LAST = 3'd4;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h46));
  endfunction

  // '0'-'9' map straight from the low nibble; 'A'-'F' (bit 6 set) need +9.
  function automatic logic [3:0] hex_to_nibble(input logic [7:0] c);
    return c[3:0] + (c[6] ? 4'd9 : 4'd0);
  endfunction

  function automatic logic hdr_char_ok(input logic [2:0] pos, input logic [7:0] c);
    case (pos)
      3'd0, 3'd1: return is_upper(c);
      3'd2:       return c == 8'h52;  // 'R'
      3'd3:       return c == 8'h4D;  // 'M'
      3'd4:       return c == 8'h43;  // 'C'
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/nmea_field_buf.sv
// Shadow character buffer for one ASCII field, copied to the live output on commit.
// Latency: live output updates on the clock edge where commit is high.
// Backpressure: none; characters past LEN are silently dropped.
module nmea_field_buf
  import nmea_pkg::*;
#(
  parameter int LEN = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr,
  input  logic [7:0]       wr_data,
  input  logic             commit,
  output logic [8*LEN-1:0] live
);

  localparam int IW = $clog2(LEN + 1);

  logic [8*LEN-1:0] r_shadow;
  logic [8*LEN-1:0] r_live;
  logic [IW-1:0]    r_idx;

  // Fill the shadow left to right, restart it on clr, publish it on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= {LEN{CH_ZERO}};
      r_live   <= {LEN{CH_ZERO}};
      r_idx    <= '0;
    end else begin
      if (clr) begin
        r_shadow <= {LEN{CH_ZERO}};
        r_idx    <= '0;
      end else if (wr && (r_idx < IW'(LEN))) begin
        r_shadow[8*r_idx +: 8] <= wr_data;
        r_idx                  <= r_idx + 1'b1;
      end
      if (commit) begin
        r_live <= r_shadow;
      end
    end
  end

  assign live = r_live;

endmodule

// File: rtl/nmea_rmc_extractor.sv
// RMC sentence parser: shadows status/lat/lon/speed/course, commits them atomically on a clean end.
// Latency: outputs and sent_ok/sent_err appear one cycle after the deciding byte.
// Backpressure: none; only rx_valid cycles advance. Define NMEA_CHECKSUM_EN to require a matching checksum.
module nmea_rmc_extractor
  import nmea_pkg::*;
#(
  parameter int LAT_LEN  = 10,
  parameter int LON_LEN  = 11,
  parameter int SPD_LEN  = 6,
  parameter int COG_LEN  = 6,
  parameter int MAX_SENT = 82
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 fix_valid,
  output logic [8*LAT_LEN-1:0] lat,
  output logic                 lat_south,
  output logic [8*LON_LEN-1:0] lon,
  output logic                 lon_west,
  output logic [8*SPD_LEN-1:0] spd,
  output logic [8*COG_LEN-1:0] cog,
  output logic                 sent_ok,
  output logic                 sent_err
);

  localparam int CW = $clog2(MAX_SENT + 2);

  state_t        r_state;
  logic [2:0]    r_hdr_cnt;
  logic [CW-1:0] r_byte_cnt;
  logic [3:0]    r_comma;
  logic          r_sh_fix, r_sh_south, r_sh_west;
  logic          r_fix_valid, r_lat_south, r_lon_west;
  logic          r_sent_ok, r_sent_err;
`ifdef NMEA_CHECKSUM_EN
  logic [7:0]    r_xor;
  logic [3:0]    r_cks_hi;
`endif

  logic w_dollar, w_take, w_body, w_star, w_eol, w_ovf;
  logic w_hdr_ok, w_hdr_done, w_fld_chr, w_commit;

  // '$' always wins: it restarts the header from any state.
  assign w_dollar   = rx_valid && (rx_data == CH_DOLLAR);
  assign w_take     = rx_valid && !w_dollar;
  assign w_body     = w_take && (r_state == ST_BODY);
  assign w_star     = (rx_data == CH_STAR);
  assign w_eol      = (rx_data == CH_CR) || (rx_data == CH_LF);
  assign w_ovf      = (r_byte_cnt >= CW'(MAX_SENT));
  assign w_hdr_ok   = hdr_char_ok(r_hdr_cnt, rx_data);
  assign w_hdr_done = w_take && (r_state == ST_HDR) && w_hdr_ok && (r_hdr_cnt == HDR_LAST);
  assign w_fld_chr  = w_body && !w_star && !w_eol && !w_ovf && (rx_data != CH_COMMA);

`ifdef NMEA_CHECKSUM_EN
  assign w_commit = w_take && (r_state == ST_CKS_LO) && is_hex(rx_data) &&
                    ({r_cks_hi, hex_to_nibble(rx_data)} == r_xor);
`else
  assign w_commit = w_body && (w_star || (rx_data == CH_CR));
`endif

  // Sentence FSM, byte counting, comma tracking and the single-bit shadow flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_hdr_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_comma     <= '0;
      r_sh_fix    <= 1'b0;
      r_sh_south  <= 1'b0;
      r_sh_west   <= 1'b0;
      r_fix_valid <= 1'b0;
      r_lat_south <= 1'b0;
      r_lon_west  <= 1'b0;
      r_sent_ok   <= 1'b0;
      r_sent_err  <= 1'b0;
`ifdef NMEA_CHECKSUM_EN
      r_xor       <= '0;
      r_cks_hi    <= '0;
`endif
    end else begin
      r_sent_ok  <= 1'b0;
      r_sent_err <= 1'b0;
      if (w_commit) begin
        r_sent_ok   <= 1'b1;
        r_fix_valid <= r_sh_fix;
        r_lat_south <= r_sh_south;
        r_lon_west  <= r_sh_west;
      end
      if (w_dollar) begin
        if ((r_state != ST_IDLE) && (r_state != ST_HDR)) r_sent_err <= 1'b1;
        r_state    <= ST_HDR;
        r_hdr_cnt  <= '0;
        r_byte_cnt <= '0;
`ifdef NMEA_CHECKSUM_EN
        r_xor      <= '0;
`endif
      end else if (rx_valid) begin
        case (r_state)
          ST_HDR: begin
            if (!w_hdr_ok) begin
              r_state <= ST_IDLE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
`ifdef NMEA_CHECKSUM_EN
              r_xor      <= r_xor ^ rx_data;
`endif
              if (r_hdr_cnt == HDR_LAST) begin
                r_state    <= ST_BODY;
                r_comma    <= '0;
                r_sh_fix   <= 1'b0;
                r_sh_south <= 1'b0;
                r_sh_west  <= 1'b0;
              end else begin
                r_hdr_cnt <= r_hdr_cnt + 1'b1;
              end
            end
          end
          ST_BODY: begin
            if (w_star) begin
`ifdef NMEA_CHECKSUM_EN
              r_state <= ST_CKS_HI;
`else
              r_state <= ST_IDLE;
`endif
            end else if (w_ovf || w_eol) begin
              r_state <= ST_IDLE;
`ifdef NMEA_CHECKSUM_EN
              r_sent_err <= 1'b1;
`else
              // CR is a clean end here; bare LF just drops the sentence quietly.
              r_sent_err <= w_ovf && (rx_data != CH_CR);
`endif
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
`ifdef NMEA_CHECKSUM_EN
              r_xor      <= r_xor ^ rx_data;
`endif
              if (rx_data == CH_COMMA) begin
                if (r_comma != 4'hF) r_comma <= r_comma + 1'b1;
              end else begin
                case (r_comma)
                  FLD_STATUS: r_sh_fix   <= (rx_data == 8'h41);  // 'A'
                  FLD_NS:     r_sh_south <= (rx_data == 8'h53);  // 'S'
                  FLD_EW:     r_sh_west  <= (rx_data == 8'h57);  // 'W'
                  default: ;
                endcase
              end
            end
          end
`ifdef NMEA_CHECKSUM_EN
          ST_CKS_HI: begin
            if (is_hex(rx_data)) begin
              r_cks_hi <= hex_to_nibble(rx_data);
              r_state  <= ST_CKS_LO;
            end else begin
              r_state    <= ST_IDLE;
              r_sent_err <= 1'b1;
            end
          end
          ST_CKS_LO: begin
            r_state <= ST_IDLE;
            if (!w_commit) r_sent_err <= 1'b1;
          end
`endif
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  nmea_field_buf #(.LEN(LAT_LEN)) u_lat (
    .clk(clk), .rst_n(rst_n), .clr(w_hdr_done), .wr(w_fld_chr && (r_comma == FLD_LAT)),
    .wr_data(rx_data), .commit(w_commit), .live(lat)
  );
  nmea_field_buf #(.LEN(LON_LEN)) u_lon (
    .clk(clk), .rst_n(rst_n), .clr(w_hdr_done), .wr(w_fld_chr && (r_comma == FLD_LON)),
    .wr_data(rx_data), .commit(w_commit), .live(lon)
  );
  nmea_field_buf #(.LEN(SPD_LEN)) u_spd (
    .clk(clk), .rst_n(rst_n), .clr(w_hdr_done), .wr(w_fld_chr && (r_comma == FLD_SPD)),
    .wr_data(rx_data), .commit(w_commit), .live(spd)
  );
  nmea_field_buf #(.LEN(COG_LEN)) u_cog (
    .clk(clk), .rst_n(rst_n), .clr(w_hdr_done), .wr(w_fld_chr && (r_comma == FLD_COG)),
    .wr_data(rx_data), .commit(w_commit), .live(cog)
  );

  assign fix_valid = r_fix_valid;
  assign lat_south = r_lat_south;
  assign lon_west  = r_lon_west;
  assign sent_ok   = r_sent_ok;
  assign sent_err  = r_sent_err;

endmodule
